ip2_scanout_capture: RTL and testbench



---
 rtl/ip2_scanout_capture.sv | 180 ++++++++++++++++++
 tb/tb_ip2_scanout_capture.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip2_scanout_capture.sv
// Scan-chain readout: samples scan_out once per bit period and packs the bits
// LSB-first into WORD_W-bit words presented on a valid/ready output register.
module ip2_scanout_capture #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [5:0]        clk_counter,
  input  logic [5:0]        test_delay,
  input  logic [5:0]        sample_phase,
  input  logic              capture_start_re,
  input  logic [CNT_W-1:0]  bit_cnt_max,
  input  logic              scan_out,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_last,
  input  logic              word_ready,
  output logic [2:0]        sm_state,
  output logic              busy,
  output logic              status_done,
  output logic              status_overflow,
  output logic [CNT_W-1:0]  bit_cnt
);

  localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ARM     = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_DRAIN   = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        state_reg, state_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [WB_W-1:0]   word_bit_reg, word_bit_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [WORD_W-1:0] word_data_reg, word_data_next;
  logic              word_valid_reg, word_valid_next;
  logic              word_last_reg, word_last_next;
  logic              done_reg, done_next;
  logic              overflow_reg, overflow_next;

  logic              sample_hit;
  logic              final_bit;
  logic              word_full;
  logic              word_done;
  logic              out_free;
  logic [WORD_W-1:0] sample_word;

  assign sample_hit = (state_reg == ST_CAPTURE) && (clk_counter == sample_phase);
  assign final_bit  = (bit_cnt_reg == bit_cnt_max);
  assign word_full  = (word_bit_reg == WB_W'(WORD_W - 1));
  assign word_done  = sample_hit && (word_full || final_bit);
  // The output register counts as free when it is empty or being drained this cycle.
  assign out_free   = ~word_valid_reg | word_ready;

  // Shift word with the current scan_out bit merged in at word_bit; higher
  // positions are still zero, so a short final word reads zero-padded.
  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_sample_word
      assign sample_word[gi] = (word_bit_reg == WB_W'(gi)) ? scan_out : shift_reg[gi];
    end
  endgenerate

  always_comb begin
    state_next      = state_reg;
    shift_next      = shift_reg;
    word_bit_next   = word_bit_reg;
    bit_cnt_next    = bit_cnt_reg;
    word_data_next  = word_data_reg;
    word_valid_next = word_valid_reg;
    word_last_next  = word_last_reg;
    done_next       = done_reg;
    overflow_next   = overflow_reg;

    case (state_reg)
      ST_IDLE: begin
        if (capture_start_re) begin
          state_next    = ST_ARM;
          done_next     = 1'b0;
          overflow_next = 1'b0;
          bit_cnt_next  = '0;
          word_bit_next = '0;
          shift_next    = '0;
        end
      end

      ST_ARM: begin
        if (clk_counter == test_delay) begin
          state_next = ST_CAPTURE;
        end
      end

      ST_CAPTURE: begin
        if (sample_hit) begin
          bit_cnt_next = bit_cnt_reg + CNT_W'(1);
          if (word_done) begin
            shift_next    = '0;
            word_bit_next = '0;
            if (final_bit) begin
              state_next = ST_DRAIN;
            end
          end else begin
            shift_next    = sample_word;
            word_bit_next = word_bit_reg + WB_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (!word_valid_reg) begin
          state_next = ST_DONE;
        end
      end

      ST_DONE: begin
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Output register: a completed word loads when there is room, otherwise it
    // is dropped, but an end-of-capture marker is kept on the held word.
    if (word_done) begin
      if (out_free) begin
        word_data_next  = sample_word;
        word_valid_next = 1'b1;
        word_last_next  = final_bit;
      end else begin
        overflow_next = 1'b1;
        if (final_bit) begin
          word_last_next = 1'b1;
        end
      end
    end else if (word_valid_reg && word_ready) begin
      word_valid_next = 1'b0;
      word_last_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      state_reg      <= ST_IDLE;
      shift_reg      <= '0;
      word_bit_reg   <= '0;
      bit_cnt_reg    <= '0;
      word_data_reg  <= '0;
      word_valid_reg <= 1'b0;
      word_last_reg  <= 1'b0;
      done_reg       <= 1'b0;
      overflow_reg   <= 1'b0;
    end else begin
      state_reg      <= state_next;
      shift_reg      <= shift_next;
      word_bit_reg   <= word_bit_next;
      bit_cnt_reg    <= bit_cnt_next;
      word_data_reg  <= word_data_next;
      word_valid_reg <= word_valid_next;
      word_last_reg  <= word_last_next;
      done_reg       <= done_next;
      overflow_reg   <= overflow_next;
    end
  end

  assign word_data       = word_data_reg;
  assign word_valid      = word_valid_reg;
  assign word_last       = word_last_reg;
  assign sm_state        = state_reg;
  assign busy            = (state_reg != ST_IDLE);
  assign status_done     = done_reg;
  assign status_overflow = overflow_reg;
  assign bit_cnt         = bit_cnt_reg;

endmodule

// File: tb/tb_ip2_scanout_capture.sv
// Self-checking bench for ip2_scanout_capture: a transaction-level model of the
// bit stream and output register predicts every handshake word and flag.
module tb_ip2_scanout_capture;

  localparam int W  = 32;
  localparam int CW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [5:0]    clk_counter;
  logic [5:0]    test_delay;
  logic [5:0]    sample_phase;
  logic          capture_start_re;
  logic [CW-1:0] bit_cnt_max;
  logic          scan_out;
  logic [W-1:0]  word_data;
  logic          word_valid;
  logic          word_last;
  logic          word_ready;
  logic [2:0]    sm_state;
  logic          busy;
  logic          status_done;
  logic          status_overflow;
  logic [CW-1:0] bit_cnt;

  ip2_scanout_capture #(.WORD_W(W), .CNT_W(CW)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .clk_counter      (clk_counter),
    .test_delay       (test_delay),
    .sample_phase     (sample_phase),
    .capture_start_re (capture_start_re),
    .bit_cnt_max      (bit_cnt_max),
    .scan_out         (scan_out),
    .word_data        (word_data),
    .word_valid       (word_valid),
    .word_last        (word_last),
    .word_ready       (word_ready),
    .sm_state         (sm_state),
    .busy             (busy),
    .status_done      (status_done),
    .status_overflow  (status_overflow),
    .bit_cnt          (bit_cnt)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: phase 0 idle, 1 waiting for boundary, 2 sampling, 3 finished
  int           phase = 0;
  int           idx = 0;
  int           bmax_m = 0;
  int           nsamp = 0;
  int           ready_mode = 0;
  logic         rel = 1'b0;
  logic         mv = 1'b0;
  logic         mlast = 1'b0;
  logic         movf = 1'b0;
  logic [W-1:0] mdata = '0;
  logic [W-1:0] mshift = '0;
  logic         bits [0:1023];
  logic [W-1:0] pq_data [$];
  logic         pq_last [$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic rst_pre, rdy_pre, b_pre, pop, s_edge, a_edge, start_pre, comp, lastw;
    int   bpos;
    rst_pre   = reset || !enable;
    rdy_pre   = word_ready;
    b_pre     = scan_out;
    pop       = !rst_pre && mv && rdy_pre;
    s_edge    = !rst_pre && phase == 2 && clk_counter == sample_phase && idx <= bmax_m;
    a_edge    = !rst_pre && phase == 1 && clk_counter == test_delay;
    start_pre = !rst_pre && phase == 0 && capture_start_re;
    if (pop) begin
      check_val("pop_data", 64'(word_data), 64'(mdata));
      check_val("pop_last", 64'(word_last), 64'(mlast));
      pq_data.push_back(word_data);
      pq_last.push_back(word_last);
      $display("word %0d: data=0x%08h last=%0b", pq_data.size() - 1, word_data, word_last);
    end
    @(posedge clk);
    #1;
    comp  = 1'b0;
    lastw = 1'b0;
    if (rst_pre) begin
      phase = 0; idx = 0; nsamp = 0;
      mv = 1'b0; mlast = 1'b0; movf = 1'b0; mshift = '0; mdata = '0;
    end else begin
      if (start_pre) begin
        phase = 1; idx = 0; nsamp = 0; movf = 1'b0; mshift = '0;
      end
      if (a_edge) phase = 2;
      if (s_edge) begin
        bpos         = idx % W;
        mshift[bpos] = b_pre;
        comp         = (bpos == W - 1) || (idx == bmax_m);
        lastw        = (idx == bmax_m);
        idx++;
        nsamp++;
      end
      if (comp) begin
        if (!mv || rdy_pre) begin
          mv = 1'b1; mdata = mshift; mlast = lastw;
        end else begin
          movf = 1'b1;
          if (lastw) mlast = 1'b1;
        end
        mshift = '0;
        if (lastw) phase = 3;
      end else if (pop) begin
        mv = 1'b0; mlast = 1'b0;
      end
    end
    check_val("valid", 64'(word_valid), 64'(mv));
    check_val("bit_cnt", 64'(bit_cnt), 64'(idx));
    if (clk_counter >= test_delay) clk_counter = '0;
    else clk_counter = clk_counter + 6'd1;
    scan_out = (idx <= bmax_m) ? bits[idx] : 1'b0;
    case (ready_mode)
      0:       word_ready = 1'b1;
      1:       word_ready = 1'($urandom_range(0, 1));
      default: word_ready = rel;
    endcase
  endtask

  task automatic begin_capture(input int td, input int sp, input int bm, input int pat, input int rmode);
    test_delay   = 6'(td);
    sample_phase = 6'(sp);
    bit_cnt_max  = CW'(bm);
    bmax_m       = bm;
    for (int i = 0; i < 1024; i++) begin
      case (pat)
        0:       bits[i] = (i % 2 == 0);
        1:       bits[i] = 1'b1;
        default: bits[i] = 1'($urandom_range(0, 1));
      endcase
    end
    ready_mode = rmode;
    rel        = 1'b0;
    word_ready = (rmode == 0);
    scan_out   = bits[0];
    pq_data.delete();
    pq_last.delete();
    capture_start_re = 1'b1;
    tick();
    capture_start_re = 1'b0;
    check_val("start_state", 64'(sm_state), 64'd1);
    check_val("start_busy", 64'(busy), 64'd1);
  endtask

  task automatic wait_idx(input int n);
    int lim = 4000;
    while (idx < n && lim > 0) begin
      tick();
      lim--;
    end
    if (lim == 0) check_val("wait_idx_timeout", 64'd0, 64'd1);
  endtask

  task automatic finish_capture(input int bm);
    int lim = (bm + 2) * (int'(test_delay) + 2) + 200;
    while (!(phase == 3 && !busy) && lim > 0) begin
      tick();
      lim--;
    end
    if (lim == 0) check_val("finish_timeout", 64'd0, 64'd1);
    check_val("done", 64'(status_done), 64'd1);
    check_val("overflow", 64'(status_overflow), 64'(movf));
    check_val("final_bit_cnt", 64'(bit_cnt), 64'(bm + 1));
    check_val("end_busy", 64'(busy), 64'd0);
    if (pq_last.size() > 0) check_val("last_on_final", 64'(pq_last[pq_last.size() - 1]), 64'd1);
    phase = 0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clk_counter = '0; test_delay = 6'd3; sample_phase = 6'd2;
    capture_start_re = 1'b0; bit_cnt_max = '0; scan_out = 1'b0; word_ready = 1'b1;
    for (int i = 0; i < 1024; i++) bits[i] = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_val("rst_state", 64'(sm_state), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_data", 64'(word_data), 64'd0);
    check_val("rst_last", 64'(word_last), 64'd0);
    check_val("rst_done", 64'(status_done), 64'd0);
    check_val("rst_ovf", 64'(status_overflow), 64'd0);

    // Alternating pattern, 64 bits
    begin_capture(3, 2, 63, 0, 0);
    finish_capture(63);
    check_val("alt_count", 64'(pq_data.size()), 64'd2);
    if (pq_data.size() == 2) begin
      check_val("alt_w0", 64'(pq_data[0]), 64'h5555_5555);
      check_val("alt_l0", 64'(pq_last[0]), 64'd0);
      check_val("alt_w1", 64'(pq_data[1]), 64'h5555_5555);
      check_val("alt_l1", 64'(pq_last[1]), 64'd1);
    end

    // 40 ones: short final word zero-padded
    begin_capture(3, 2, 39, 1, 0);
    finish_capture(39);
    check_val("ones_count", 64'(pq_data.size()), 64'd2);
    if (pq_data.size() == 2) begin
      check_val("ones_w0", 64'(pq_data[0]), 64'hFFFF_FFFF);
      check_val("ones_l0", 64'(pq_last[0]), 64'd0);
      check_val("ones_w1", 64'(pq_data[1]), 64'h0000_00FF);
      check_val("ones_l1", 64'(pq_last[1]), 64'd1);
    end

    // Consumer stalled for the whole capture: later words dropped
    begin_capture(3, 2, 95, 0, 2);
    begin
      int lim = 2000;
      while (phase != 3 && lim > 0) begin tick(); lim--; end
      if (lim == 0) check_val("stall_timeout", 64'd0, 64'd1);
    end
    check_val("stall_valid", 64'(word_valid), 64'd1);
    check_val("stall_data", 64'(word_data), 64'h5555_5555);
    check_val("stall_last", 64'(word_last), 64'd1);
    check_val("stall_ovf", 64'(status_overflow), 64'd1);
    check_val("stall_notdone", 64'(status_done), 64'd0);
    rel = 1'b1;
    finish_capture(95);
    check_val("stall_count", 64'(pq_data.size()), 64'd1);

    // Reset in the middle of a capture, then a clean rerun
    begin_capture(3, 2, 63, 2, 0);
    wait_idx(17);
    check_val("mid_bit_cnt", 64'(bit_cnt), 64'd17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("abort_state", 64'(sm_state), 64'd0);
    check_val("abort_valid", 64'(word_valid), 64'd0);
    check_val("abort_bit_cnt", 64'(bit_cnt), 64'd0);
    begin_capture(3, 2, 63, 2, 0);
    finish_capture(63);
    check_val("rerun_count", 64'(pq_data.size()), 64'd2);

    // Enable dropped mid-capture
    begin_capture(2, 1, 63, 2, 0);
    wait_idx(10);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check_val("en_state", 64'(sm_state), 64'd0);
    check_val("en_valid", 64'(word_valid), 64'd0);
    check_val("en_bit_cnt", 64'(bit_cnt), 64'd0);
    check_val("en_done", 64'(status_done), 64'd0);

    // Start pulse during CAPTURE is ignored
    begin_capture(4, 1, 63, 2, 0);
    wait_idx(20);
    capture_start_re = 1'b1;
    tick();
    capture_start_re = 1'b0;
    check_val("ign_state", 64'(sm_state), 64'd2);
    finish_capture(63);
    check_val("ign_count", 64'(pq_data.size()), 64'd2);

    // Sampling on the boundary cycle: 6-cycle period, valid one cycle after 32nd sample
    begin_capture(5, 5, 63, 1, 0);
    begin
      int lim = 1000;
      while (nsamp < 32 && lim > 0) begin tick(); lim--; end
      if (lim == 0) check_val("lat_timeout", 64'd0, 64'd1);
    end
    check_val("lat_valid", 64'(word_valid), 64'd1);
    check_val("lat_phase", 64'(clk_counter), 64'd0);
    finish_capture(63);
    check_val("bnd_count", 64'(pq_data.size()), 64'd2);
    if (pq_data.size() == 2) check_val("bnd_w1", 64'(pq_data[1]), 64'hFFFF_FFFF);

    // Randomized captures with random back-pressure
    for (int t = 0; t < 6; t++) begin
      int td, sp, bm;
      td = $urandom_range(0, 7);
      sp = $urandom_range(0, td);
      bm = $urandom_range(0, 200);
      $display("random run %0d: test_delay=%0d sample_phase=%0d bit_cnt_max=%0d", t, td, sp, bm);
      begin_capture(td, sp, bm, 2, 1);
      finish_capture(bm);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
